bcd_to_binary: RTL
==================

Name: bcd_to_binary

Overview:
Sequential converter from packed BCD to unsigned binary, using reverse double-dabble (shift-right / subtract-3). It is the inverse of the ALU's binary-to-BCD output stage. It turns operator-entered or displayed decimal values back into binary operands and result checks. Valid/ready handshakes are used on both sides, and one conversion is in flight at a time.

Parameters:
DIGITS, 3, number of BCD digits on input; input width is 4*DIGITS.
BIN_W, 10, binary output width and number of iterations; must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  upstream presents a BCD word.
in_ready  output  1  block can accept a word (high only in IDLE).
bcd  input  4*DIGITS  packed BCD, digit 0 in bits [3:0].
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
binary  output  BIN_W  converted value; 0 when digit_err is set.
digit_err  output  1  an input nibble was greater than 9.
ovf8  output  1  binary > 255, i.e. the value exceeds the ALU 8-bit result range.

Behaviour:
- Reset is synchronous, active-low, on clk only. It puts the FSM in IDLE and sets in_ready=1, out_valid=0, binary=0, digit_err=0, ovf8=0, iteration counter=0.
- States:
  - IDLE: in_ready=1. When in_valid is high:
    - If any nibble of bcd is greater than 9, latch digit_err=1 and binary=0, and go to DONE.
    - Otherwise load the working register W = {bcd, BIN_W'b0}, clear the counter, and go to SHIFT.
  - SHIFT: one step per clock.
    - Shift W right by 1; bit 0 of the BCD field enters the MSB of the binary field.
    - Then, in the same cycle, every BCD digit of the shifted value that is >= 8 has 3 subtracted.
    - The counter increments. After step BIN_W (counter == BIN_W-1 at the edge), go to DONE.
  - DONE: out_valid=1. binary, digit_err and ovf8 are held stable. When out_ready is high, go to IDLE next cycle.
- Latency:
  - Valid input: accepted at edge T; out_valid is high in the cycle after edge T+BIN_W (10 steps at default parameters).
  - Error input: out_valid is high in the cycle after edge T (1 cycle).
- in_ready is low in SHIFT and DONE. There is no accept in the same cycle as the output transfer, so peak throughput is one result per BIN_W+2 cycles.
- At the end of a valid conversion the BCD field of W is zero (internal invariant; verification asserts it).
- ovf8 is the OR of binary[BIN_W-1:8]. It is registered and updated only on entry to DONE.
- in_valid is ignored outside IDLE; the bcd input need not be held after acceptance.
- out_ready high while out_valid is low has no effect.
- Reset mid-conversion aborts: IDLE the next cycle and partial results are discarded. No output is produced for the aborted word.
- Outputs never change while out_valid=1 and out_ready=0.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - constants DIGIT_MAX=9, ADJ_THRESH=8, ADJ_SUB=3;
  - function for the ceil-log2 check of BIN_W against DIGITS (compile-time assertion).
- Sub-module bcd_digit_adj: 4-bit combinational corrector (d>=8 ? d-3 : d), instantiated DIGITS times by generate. The FSM, counter and W register live in the top.

Test Plan:
- bcd=12'h000, out_ready=1 -> binary=0, ovf8=0, digit_err=0; out_valid rises 10 cycles after accept.
- bcd=12'h225 -> binary=10'h0E1 (225), ovf8=0; then bcd=12'h999 -> binary=10'h3E7 (999), ovf8=1; bcd=12'h256 -> binary=256, ovf8=1.
- bcd=12'h1A3 -> digit_err=1, binary=0, out_valid one cycle after accept, no SHIFT cycles.
- Backpressure: convert 12'h042, hold out_ready=0 for 5 cycles -> out_valid and binary=42 stable throughout; in_ready=0 and a second in_valid is ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset: drop rst_n for one cycle at step 4 of converting 12'h777 -> next cycle IDLE, in_ready=1, out_valid=0, binary=0; a following 12'h015 converts to 15 with normal latency.
- Round trip: sweep 0..255 through the team's binary-to-BCD converter into this block -> binary equals the original value, ovf8=0, digit_err=0 for all.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcdState;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;

  // Smallest binary width that can hold the largest value of 'digits' BCD digits.
  function automatic int minBinWidth(input int digits);
    longint maxVal;
    int width;
    maxVal = 1;
    for (int i = 0; i < digits; i++) begin
      maxVal = maxVal * 10;
    end
    maxVal = maxVal - 1;
    width = 0;
    while ((longint'(1) << width) <= maxVal) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One-digit corrector for reverse double-dabble: digits that reach 8 after a
// right shift lose 3, undoing the halving carry of 10 into 5.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digitIn,
  output logic [3:0] digitOut
);

  assign digitOut = (digitIn >= ADJ_THRESH) ? (digitIn - ADJ_SUB) : digitIn;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter, one conversion in flight.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a BCD word
//   SHIFT | one shift/correct step per clock, BIN_W steps total
//   DONE  | out_valid high, result held until out_ready
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      binary,
  output logic                  digit_err,
  output logic                  ovf8
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  if (BIN_W < minBinWidth(DIGITS)) begin : gBinWidthCheck
    $error("bcd_to_binary: BIN_W is too narrow for DIGITS");
  end

  bcdState            state;
  bcdState            nextState;
  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  workShifted;
  logic [WORK_W-1:0]  workAdj;
  logic [CNT_W-1:0]   stepCount;
  logic               digitBad;
  logic               ovfNext;
  logic               lastStep;

  assign workShifted = work >> 1;
  assign workAdj[BIN_W-1:0] = workShifted[BIN_W-1:0];
  assign lastStep = (stepCount == LAST_STEP);

  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    bcd_digit_adj uAdj (
      .digitIn  (workShifted[BIN_W+4*g +: 4]),
      .digitOut (workAdj[BIN_W+4*g +: 4])
    );
  end

  // Flag any input nibble outside the decimal range.
  always_comb begin
    digitBad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > DIGIT_MAX) begin
        digitBad = 1'b1;
      end
    end
  end

  // Result exceeds the 8-bit ALU range when any bit above bit 7 is set.
  always_comb begin
    ovfNext = 1'b0;
    for (int i = 8; i < BIN_W; i++) begin
      ovfNext = ovfNext | workAdj[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          nextState = digitBad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (lastStep) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Working register, step counter and result registers; results only move on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work      <= '0;
      stepCount <= '0;
      binary    <= '0;
      digit_err <= 1'b0;
      ovf8      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (digitBad) begin
              binary    <= '0;
              digit_err <= 1'b1;
              ovf8      <= 1'b0;
            end else begin
              work      <= {bcd, {BIN_W{1'b0}}};
              stepCount <= '0;
            end
          end
        end
        SHIFT: begin
          work      <= workAdj;
          stepCount <= stepCount + CNT_W'(1);
          if (lastStep) begin
            binary    <= workAdj[BIN_W-1:0];
            digit_err <= 1'b0;
            ovf8      <= ovfNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
